// File: rtl/integral_image_builder_pkg.sv
// Shared constants and types for the integral-image builder, display and detector.
package integral_image_builder_pkg;

    localparam int II_WIDTH  = 160;
    localparam int II_HEIGHT = 120;
    localparam int PIX_W     = 4;
    localparam int II_W      = 20;
    localparam int ADDR_W    = 15;
    localparam int COL_W     = $clog2(II_WIDTH);
    localparam int ROW_W     = $clog2(II_HEIGHT);

    typedef logic [II_W-1:0] ii_val_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ii_state_e;

endpackage

// File: rtl/integral_image_builder_if.sv
// Pixel-stream input and integral-image memory write port of the builder.
interface integral_image_builder_if;
    import integral_image_builder_pkg::*;

    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_sof;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    ii_val_t           wr_data;
    logic              busy;
    logic              frame_done;
    logic              frame_err;

    modport master (
        output pix_data, pix_valid, pix_sof,
        input  wr_en, wr_addr, wr_data, busy, frame_done, frame_err
    );

    modport slave (
        input  pix_data, pix_valid, pix_sof,
        output wr_en, wr_addr, wr_data, busy, frame_done, frame_err
    );

endinterface

// File: rtl/integral_image_builder_ii_row_delay.sv
// One-row delay line: head_o is the value pushed exactly DEPTH accepted pixels ago.
module ii_row_delay
    import integral_image_builder_pkg::*;
#(
    parameter int DEPTH = II_WIDTH,
    parameter int WIDTH = II_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else if (shift_en_i) begin
            sr_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign head_o = sr_q[DEPTH-1];

endmodule

// File: rtl/integral_image_builder.sv
// Streams 160x120 pixels into a raster-ordered integral image (row sum + value one row up).
//   state     | meaning
//   ST_IDLE   | waiting for pix_valid & pix_sof; other pixels ignored
//   ST_ACTIVE | frame in progress; every valid pixel is accumulated and written
module integral_image_builder
    import integral_image_builder_pkg::*;
(
    input  logic                     clk_cam,
    input  logic                     rst_n,
    integral_image_builder_if.slave  bus
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(II_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(II_HEIGHT - 1);

    ii_state_e         state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d, col_cur;
    logic [ROW_W-1:0]  row_q, row_d, row_cur;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_cur;
    ii_val_t           row_sum_q, row_sum_d;
    ii_val_t           rs, up, ii, head;
    logic              start, accept, last;

    logic              wr_en_q, frame_done_q, frame_err_q;
    logic [ADDR_W-1:0] wr_addr_q;
    ii_val_t           wr_data_q;

    always_comb begin
        start     = bus.pix_valid & bus.pix_sof;
        accept    = bus.pix_valid & (bus.pix_sof | (state_q == ST_ACTIVE));
        // A sof pixel is always (0,0), even when it aborts a running frame.
        col_cur   = start ? '0 : col_q;
        row_cur   = start ? '0 : row_q;
        addr_cur  = start ? '0 : addr_q;
        rs        = ((col_cur == '0) ? '0 : row_sum_q) + II_W'(bus.pix_data);
        up        = (row_cur == '0) ? '0 : head;
        ii        = rs + up;
        last      = accept && (col_cur == COL_LAST) && (row_cur == ROW_LAST);

        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        row_sum_d = row_sum_q;
        if (accept) begin
            row_sum_d = rs;
            addr_d    = addr_cur + 1'b1;
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
                row_d = row_cur;
            end
            state_d = last ? ST_IDLE : ST_ACTIVE;
        end
    end

    always_ff @(posedge clk_cam or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_cam or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            row_sum_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            row_sum_q    <= row_sum_d;
            wr_en_q      <= accept;
            frame_done_q <= last;
            frame_err_q  <= start && (state_q == ST_ACTIVE);
            if (accept) begin
                wr_addr_q <= addr_cur;
                wr_data_q <= ii;
            end
        end
    end

    ii_row_delay #(
        .DEPTH (II_WIDTH),
        .WIDTH (II_W)
    ) u_row_delay (
        .clk_i      (clk_cam),
        .rst_n_i    (rst_n),
        .shift_en_i (accept),
        .din_i      (ii),
        .head_o     (head)
    );

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_integral_image_builder.sv
// Self-checking bench: directed vector table, then full frames against a 2-D prefix-sum model.
module tb_integral_image_builder;

    localparam int W = 160;
    localparam int H = 120;

    logic clk_cam = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_cam = ~clk_cam;

    integral_image_builder_if bus ();

    integral_image_builder dut (
        .clk_cam (clk_cam),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic       v;
        logic       s;
        logic [3:0] d;
        logic       en;
        int         addr;
        int         data;
        logic       err;
        logic       busy;
    } vec_t;

    typedef struct {
        int addr;
        int data;
        bit done;
        bit err;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    bit   mon_en = 1'b0;
    int   mem [W*H];
    exp_t exp_q [$];

    bit   m_active = 1'b0;
    int   m_col = 0;
    int   m_row = 0;
    int   m_ii [H][W];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: II(x,y) = p + II(x-1,y) + II(x,y-1) - II(x-1,y-1)
    task automatic drive(input logic v, input logic s, input logic [3:0] d);
        exp_t e;
        int left, upv, ul;
        @(negedge clk_cam);
        bus.pix_valid = v;
        bus.pix_sof   = s;
        bus.pix_data  = d;
        if (v && (s || m_active)) begin
            e.err = s && m_active;
            if (s) begin
                m_col = 0;
                m_row = 0;
            end
            left = (m_col > 0) ? m_ii[m_row][m_col-1] : 0;
            upv  = (m_row > 0) ? m_ii[m_row-1][m_col] : 0;
            ul   = (m_col > 0 && m_row > 0) ? m_ii[m_row-1][m_col-1] : 0;
            m_ii[m_row][m_col] = int'(d) + left + upv - ul;
            e.addr = m_row * W + m_col;
            e.data = m_ii[m_row][m_col];
            e.done = (m_row == H-1) && (m_col == W-1);
            exp_q.push_back(e);
            m_active = !e.done;
            if (m_col == W-1) begin
                m_col = 0;
                m_row++;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom));
    endtask

    // val < 0 selects random pixel data; gaps inserts 1-5 invalid cycles now and then
    task automatic run_pixels(input int n, input int val, input bit first_sof, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 7) == 0) idle($urandom_range(1, 5));
            drive(1'b1, first_sof && (i == 0), (val < 0) ? 4'($urandom_range(0, 15)) : 4'(val));
        end
    endtask

    always @(posedge clk_cam) begin
        exp_t e;
        #1;
        if (mon_en && rst_n) begin
            if (bus.wr_en) begin
                wr_cnt++;
                if (bus.frame_done) done_cnt++;
                if (bus.frame_err) err_cnt++;
                if (int'(bus.wr_addr) < W*H) mem[bus.wr_addr] = int'(bus.wr_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0d expected no write",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.wr_addr, e.addr);
                    check("wr_data", bus.wr_data, e.data);
                    check("frame_done", bus.frame_done, e.done);
                    check("frame_err", bus.frame_err, e.err);
                end
            end else begin
                check("pulses_without_write", {bus.frame_done, bus.frame_err}, 0);
            end
        end
    end

    vec_t tbl [8];

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = '0;
        repeat (3) @(posedge clk_cam);
        #1;
        check("reset_wr_en", bus.wr_en, 0);
        check("reset_outputs", {bus.wr_addr, bus.wr_data, bus.busy, bus.frame_done, bus.frame_err}, 0);
        @(negedge clk_cam);
        rst_n = 1'b1;

        tbl[0] = '{1'b1, 1'b0, 4'd7, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 4'd3, 1'b1, 0, 3, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 4'd9, 1'b0, 0, 3, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 4'd5, 1'b1, 1, 8, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 4'd1, 1'b1, 2, 9, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 4'd2, 1'b1, 0, 2, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 4'd4, 1'b1, 1, 6, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 4'd0, 1'b0, 1, 6, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_cam);
            bus.pix_valid = tbl[i].v;
            bus.pix_sof   = tbl[i].s;
            bus.pix_data  = tbl[i].d;
            @(posedge clk_cam);
            #1;
            check($sformatf("vec%0d_wr_en", i), bus.wr_en, tbl[i].en);
            check($sformatf("vec%0d_wr_addr", i), bus.wr_addr, tbl[i].addr);
            check($sformatf("vec%0d_wr_data", i), bus.wr_data, tbl[i].data);
            check($sformatf("vec%0d_frame_err", i), bus.frame_err, tbl[i].err);
            check($sformatf("vec%0d_busy", i), bus.busy, tbl[i].busy);
        end

        @(negedge clk_cam);
        bus.pix_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk_cam);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // frame with pix=1 cut by an async reset partway through row 37
        run_pixels(37*W + 50, 1, 1'b1, 1'b0);
        @(posedge clk_cam);
        #1;
        check("busy_mid_frame", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        bus.pix_valid = 1'b0;
        #1;
        check("async_reset_outputs",
              {bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.frame_done, bus.frame_err}, 0);
        check("queue_empty_at_reset", exp_q.size(), 0);
        exp_q.delete();
        m_active = 1'b0;
        @(negedge clk_cam);
        @(negedge clk_cam);
        rst_n = 1'b1;

        run_pixels(5, 9, 1'b0, 1'b0);
        done_cnt = 0;
        run_pixels(W*H, 1, 1'b1, 1'b0);
        idle(3);
        check("ones_addr0", mem[0], 1);
        check("ones_addr159", mem[159], 160);
        check("ones_addr160", mem[160], 2);
        check("ones_addr19199", mem[W*H-1], 19200);
        check("ones_done_count", done_cnt, 1);
        check("busy_after_frame", bus.busy, 0);

        run_pixels(5, 4, 1'b0, 1'b0);
        done_cnt = 0;
        run_pixels(W*H, 15, 1'b1, 1'b0);
        idle(3);
        check("max_addr19199", mem[W*H-1], 288000);
        check("max_done_count", done_cnt, 1);

        // zero frame aborted at pixel 500 by a fresh sof carrying random data with gaps
        err_cnt  = 0;
        done_cnt = 0;
        run_pixels(500, 0, 1'b1, 1'b0);
        idle(1);
        wr_cnt = 0;
        run_pixels(W*H, -1, 1'b1, 1'b1);
        idle(3);
        check("abort_err_count", err_cnt, 1);
        check("random_write_count", wr_cnt, W*H);
        check("random_done_count", done_cnt, 1);

        wr_cnt = 0;
        run_pixels(6, -1, 1'b0, 1'b0);
        idle(3);
        check("writes_after_done", wr_cnt, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/integral_image_builder.md
Name: integral_image_builder

Overview:
- Upstream neighbour of the integral-image display stage.
- Consumes a downscaled 160x120 grayscale pixel stream and computes the integral image II(x,y) = sum of all pixels p(i,j) with i<=x and j<=y.
- Writes each result to the integral-image block RAM in raster order, at address row*160+col.
- The display and detector stages read this same memory.

Parameters:
- II_WIDTH, 160, pixels per row.
- II_HEIGHT, 120, rows per frame.
- PIX_W, 4, input pixel width in bits.
- II_W, 20, integral value width in bits. Worst case is 15*19200 = 288000 < 2^20, so no overflow is possible at defaults.
- ADDR_W, 15, memory address width.

Ports:
- clk_cam  in  1  single clock domain; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pix_data  in  PIX_W  grayscale pixel.
- pix_valid  in  1  pixel qualifier; gaps of any length are allowed.
- pix_sof  in  1  start of frame; meaningful only together with pix_valid, and marks that pixel as (0,0).
- wr_en  out  1  memory write strobe.
- wr_addr  out  ADDR_W  memory write address.
- wr_data  out  II_W  integral value.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse, on the same cycle as the write of the last pixel (159,119).
- frame_err  out  1  one-cycle pulse when a frame is aborted by an early pix_sof.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; counters, row_sum and line buffer cleared.
- States:
  - IDLE: pixels without pix_sof are ignored. pix_valid&pix_sof -> ACTIVE, and that pixel is processed as (0,0).
  - ACTIVE: each pix_valid pixel is processed. On the last pixel (col=II_WIDTH-1, row=II_HEIGHT-1) -> IDLE.
- Accepted pixel at (col,row):
  - rs = (col==0 ? 0 : row_sum) + pix_data, zero-extended to II_W.
  - up = (row==0 ? 0 : line buffer head), which is II(col,row-1).
  - ii = rs + up; row_sum <= rs; ii is pushed into the line buffer.
  - col increments and wraps at II_WIDTH-1, where row increments.
- Latency: wr_en, wr_addr = row*II_WIDTH+col and wr_data = ii are registered, valid exactly 1 cycle after the accepting edge. wr_en is low in all other cycles.
- Address is computed incrementally (+1 per accepted pixel, reset to 0 on sof), not with a multiplier.
- busy: high from the cycle after sof acceptance until the cycle after the last pixel.
- frame_done: coincides with wr_en of address II_WIDTH*II_HEIGHT-1 (19199).
- pix_sof while ACTIVE:
  - frame_err pulses (1 cycle after that edge).
  - Counters, row_sum and addressing restart, and the pixel is processed as (0,0) of a new frame.
  - The line buffer need not be cleared, because row 0 forces up=0.
- Pixels arriving after frame completion without pix_sof are ignored: no write, no error.
- pix_valid low: no state change; outputs hold except that wr_en, frame_done and frame_err drop to 0.
- Reset mid-frame: immediate return to IDLE with all outputs 0. The partial frame in memory is left as is.
- Arithmetic is unsigned, with no saturation needed at defaults.
- Throughput: one pixel per clock sustained.

Decomposition:
- Shared package holds constants II_WIDTH, II_HEIGHT, II_W, ADDR_W and PIX_W, used by the builder, display and detector.
- One sub-module, ii_row_delay: a II_WIDTH-deep, II_W-wide shift register.
  - Advances only on accepted pixels (shift enable).
  - Output is the entry pushed II_WIDTH accepts ago.
  - Async active-low clear.
  - Implementation may use a shift register or a circular buffer in BRAM with read-before-write, provided the one-pixel-per-clock throughput is kept.

Test Plan:
- Constant pix_data=1, continuous valid, one sof: every write has wr_data=(col+1)*(row+1). Addr 0 = 1, addr 159 = 160, addr 160 = 2, addr 19199 = 19200. frame_done pulses once with addr 19199.
- Constant pix_data=15: addr 19199 = 288000 (0x46500), with no wrap. Pixel value 0 everywhere: all writes are 0.
- Random pix_data with random valid gaps (0-5 cycles): every write matches a reference 2-D prefix sum. The count of wr_en equals 19200, and addresses strictly increase by 1.
- Extra pixels without sof before the first sof and after frame_done: no wr_en. A following sof frame is correct.
- sof at pixel 500 of a frame: frame_err pulses once, next write is addr 0 with wr_data = that pixel, and the frame completes correctly with row-0 values unaffected by stale data.
- rst_n asserted asynchronously mid-row at row 37: outputs go to 0 without a clock edge. After release, a full frame with pix=1 reproduces the expected results from the first scenario.
